// File: rtl/io_input_port.sv
// IO read port: three async 32-bit inputs, synchronized and debounced,
// plus a sticky clear-on-read change-status word on the CPU load path.
module io_input_port #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        read_io_enable,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    input  logic [31:0] in_port2,
    output logic [31:0] dataout
);

    localparam logic [5:0] A_VIS0 = 6'b110000;
    localparam logic [5:0] A_VIS1 = 6'b110001;
    localparam logic [5:0] A_VIS2 = 6'b110010;
    localparam logic [5:0] A_CHG  = 6'b110011;

    localparam logic [CNT_W:0]   DEB_LIM = (CNT_W + 1)'(DEBOUNCE);
    localparam logic [CNT_W:0]   ONE_W   = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [2:0][31:0]    pin;
    logic [2:0][31:0]    s1_q, s1_d;
    logic [2:0][31:0]    s2_q, s2_d;
    logic [2:0][31:0]    cand_q, cand_d;
    logic [2:0][31:0]    vis_q, vis_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0][CNT_W:0] cnt_inc;
    logic [2:0]          chg_q, chg_d;
    logic [2:0]          chg_set;
    logic                chg_clr;

    assign pin[0] = in_port0;
    assign pin[1] = in_port1;
    assign pin[2] = in_port2;

    always_comb begin
        s1_d    = pin;
        s2_d    = s1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        vis_d   = vis_q;
        chg_set = '0;
        cnt_inc = '0;
        for (int n = 0; n < 3; n++) begin
            cnt_inc[n] = {1'b0, cnt_q[n]} + ONE_W;
            if (s2_q[n] == vis_q[n]) begin
                cnt_d[n] = '0;
            end else if (s2_q[n] != cand_q[n]) begin
                // new candidate value: this edge is its first qualifying sample
                cand_d[n] = s2_q[n];
                cnt_d[n]  = ONE_C;
                if (DEBOUNCE == 1) begin
                    vis_d[n] = s2_q[n];
                end
            end else if (cnt_inc[n] == DEB_LIM) begin
                vis_d[n] = s2_q[n];
                cnt_d[n] = '0;
            end else begin
                cnt_d[n] = cnt_q[n] + ONE_C;
            end
            chg_set[n] = (vis_d[n] != vis_q[n]);
        end
        chg_clr = read_io_enable && (addr[7:2] == A_CHG);
        // a flag set on the clearing edge survives the clear
        chg_d   = (chg_clr ? 3'b000 : chg_q) | chg_set;
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
            vis_q  <= '0;
            chg_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            vis_q  <= vis_d;
            chg_q  <= chg_d;
        end
    end

    always_comb begin
        dataout = 32'h0;
        case (addr[7:2])
            A_VIS0:  dataout = vis_q[0];
            A_VIS1:  dataout = vis_q[1];
            A_VIS2:  dataout = vis_q[2];
            A_CHG:   dataout = {29'b0, chg_q};
            default: dataout = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_io_input_port.sv
// Bench for io_input_port: directed scenarios with literal expectations,
// then randomized traffic checked against a run-length reference model.
module tb_io_input_port;

    localparam int DEB = 4;

    logic        io_clk;
    logic        reset;
    logic [31:0] addr;
    logic        read_io_enable;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [31:0] in_port2;
    logic [31:0] dataout;

    int n_cmp;
    int n_bad;

    // reference model state
    logic [31:0] m_s1  [3];
    logic [31:0] m_s2  [3];
    logic [31:0] m_rv  [3];
    int          m_rc  [3];
    logic [31:0] m_vis [3];
    logic [2:0]  m_chg;

    io_input_port #(.DEBOUNCE(DEB), .CNT_W(16)) dut (
        .io_clk         (io_clk),
        .reset          (reset),
        .addr           (addr),
        .read_io_enable (read_io_enable),
        .in_port0       (in_port0),
        .in_port1       (in_port1),
        .in_port2       (in_port2),
        .dataout        (dataout)
    );

    initial io_clk = 1'b0;
    always #20 io_clk = ~io_clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[7:2])
            6'h30:   return m_vis[0];
            6'h31:   return m_vis[1];
            6'h32:   return m_vis[2];
            6'h33:   return {29'b0, m_chg};
            default: return 32'h0;
        endcase
    endfunction

    // vis takes value X once the synchronized input has shown X for
    // DEB consecutive edges and X differs from what is visible now
    task automatic model_step();
        logic [31:0] pins [3];
        logic [31:0] x;
        logic [2:0]  set;
        pins[0] = in_port0;
        pins[1] = in_port1;
        pins[2] = in_port2;
        set = 3'b000;
        if (reset) begin
            for (int n = 0; n < 3; n++) begin
                m_s1[n] = '0; m_s2[n] = '0; m_rv[n] = '0;
                m_rc[n] = 0;  m_vis[n] = '0;
            end
            m_chg = 3'b000;
            return;
        end
        for (int n = 0; n < 3; n++) begin
            x = m_s2[n];
            if (x == m_rv[n]) m_rc[n]++;
            else begin
                m_rv[n] = x;
                m_rc[n] = 1;
            end
            if (m_rc[n] >= DEB && x != m_vis[n]) begin
                m_vis[n] = x;
                set[n] = 1'b1;
            end
            m_s2[n] = m_s1[n];
            m_s1[n] = pins[n];
        end
        if (read_io_enable && addr[7:2] == 6'h33) m_chg = 3'b000;
        m_chg = m_chg | set;
    endtask

    // compare current read, advance model and DUT by one edge
    task automatic tick();
        #1;
        check("dataout", dataout, model_read(addr));
        model_step();
        @(negedge io_clk);
    endtask

    // literal expectation pinning both DUT and model
    task automatic lit(input string nm, input logic [31:0] exp);
        #1;
        check({nm, "_dut"}, dataout, exp);
        check({nm, "_model"}, model_read(addr), exp);
    endtask

    function automatic logic [31:0] new_val(input logic [31:0] cur);
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return v;
            default: return cur ^ (32'h1 << v[4:0]);
        endcase
    endfunction

    initial begin
        logic [7:0]  atab [6];
        logic [31:0] r;
        int          ai;
        atab = '{8'hC0, 8'hC4, 8'hC8, 8'hCC, 8'hD0, 8'h00};
        n_cmp = 0;
        n_bad = 0;
        for (int n = 0; n < 3; n++) begin
            m_s1[n] = '0; m_s2[n] = '0; m_rv[n] = '0;
            m_rc[n] = 0;  m_vis[n] = '0;
        end
        m_chg = 3'b000;

        reset = 1'b1;
        addr = 32'hC0;
        read_io_enable = 1'b0;
        in_port0 = 32'hFFFF_FFFF;
        in_port1 = 32'h0;
        in_port2 = 32'h0;
        @(negedge io_clk);
        tick();
        tick();
        lit("rst_vis0", 32'h0);
        addr = 32'hCC;
        lit("rst_chg", 32'h0);

        reset = 1'b0;
        addr = 32'hC0;
        repeat (5) tick();
        lit("lat_before", 32'h0);
        tick();
        lit("lat_vis0", 32'hFFFF_FFFF);
        addr = 32'hCC;
        lit("lat_chg", 32'h1);

        read_io_enable = 1'b1;
        tick();
        read_io_enable = 1'b0;
        lit("clr_chg", 32'h0);

        addr = 32'hC4;
        in_port1 = 32'h5;
        tick();
        tick();
        in_port1 = 32'h0;
        repeat (8) tick();
        lit("glitch_vis1", 32'h0);
        addr = 32'hCC;
        lit("glitch_chg", 32'h0);
        in_port1 = 32'h5;
        addr = 32'hC4;
        repeat (5) tick();
        lit("q1_before", 32'h0);
        tick();
        lit("q1_vis1", 32'h5);

        addr = 32'hC8;
        in_port2 = 32'hA;
        repeat (3) tick();
        in_port2 = 32'hB;
        repeat (5) tick();
        lit("rs_noA", 32'h0);
        tick();
        lit("rs_vis2", 32'hB);

        addr = 32'hCC;
        lit("chg_pre", 32'h6);
        tick();
        lit("chg_keep", 32'h6);

        in_port0 = 32'h0;
        addr = 32'hC0;
        repeat (5) tick();
        lit("coll_vis0_old", 32'hFFFF_FFFF);
        addr = 32'hCC;
        read_io_enable = 1'b1;
        lit("coll_read", 32'h6);
        tick();
        read_io_enable = 1'b0;
        lit("coll_after", 32'h1);
        addr = 32'hC0;
        lit("coll_vis0", 32'h0);

        addr = 32'hD0;
        lit("dec_D0", 32'h0);
        addr = 32'hFFFF_FFC4;
        lit("dec_hi", 32'h5);

        in_port2 = 32'h7;
        addr = 32'hC8;
        repeat (5) tick();
        lit("mid_vis2", 32'hB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lit("mid_rst_vis2", 32'h0);
        addr = 32'hC4;
        lit("mid_rst_vis1", 32'h0);
        addr = 32'hCC;
        lit("mid_rst_chg", 32'h0);
        addr = 32'hC8;
        repeat (5) tick();
        lit("rq_before", 32'h0);
        tick();
        lit("rq_vis2", 32'h7);

        repeat (3000) begin
            if ($urandom_range(0, 9) == 0) in_port0 = new_val(in_port0);
            if ($urandom_range(0, 9) == 0) in_port1 = new_val(in_port1);
            if ($urandom_range(0, 9) == 0) in_port2 = new_val(in_port2);
            r = $urandom;
            ai = $urandom_range(0, 5);
            addr = {r[31:8], atab[ai][7:2], r[1:0]};
            read_io_enable = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
